// File: rtl/cache_ctrl_perf_pkg.sv
// ============================================================================
//  Module   : cache_ctrl_perf_pkg
//  Brief    : CTRL address map and FSM state encoding for cache_ctrl_perf.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_ctrl_perf_pkg;

    localparam int unsigned c_addr_hit_total   = 0;
    localparam int unsigned c_addr_miss_total  = 1;
    localparam int unsigned c_addr_reset_cnt   = 2;
    localparam int unsigned c_addr_invalidate  = 3;
    localparam int unsigned c_addr_buf_empty   = 4;
    localparam int unsigned c_addr_buf_full    = 5;
    localparam int unsigned c_addr_freeze_on   = 6;
    localparam int unsigned c_addr_freeze_off  = 7;
    localparam int unsigned c_addr_cnt_base    = 8;
    localparam int unsigned c_cnt_per_ch       = 4;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_INV_WAIT = 2'd1,
        S_INV_ACK  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/cache_ctrl_perf_if.sv
// ============================================================================
//  Module   : cache_ctrl_perf_if
//  Brief    : CTRL request/response, invalidate handshake and event bundle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cache_ctrl_perf_if #(
    parameter int FE_DATA_W   = 32,
    parameter int CTRL_ADDR_W = 5,
    parameter int N_CH        = 2
);
    logic                   valid;
    logic [CTRL_ADDR_W-1:0] addr;
    logic [FE_DATA_W-1:0]   rdata;
    logic                   ready;
    logic                   invalidate;
    logic                   inv_done;
    logic                   wtbuf_full;
    logic                   wtbuf_empty;
    logic [N_CH-1:0]        read_hit;
    logic [N_CH-1:0]        read_miss;
    logic [N_CH-1:0]        write_hit;
    logic [N_CH-1:0]        write_miss;

    modport master (
        output valid, addr, inv_done, wtbuf_full, wtbuf_empty,
               read_hit, read_miss, write_hit, write_miss,
        input  rdata, ready, invalidate
    );

    modport slave (
        input  valid, addr, inv_done, wtbuf_full, wtbuf_empty,
               read_hit, read_miss, write_hit, write_miss,
        output rdata, ready, invalidate
    );
endinterface

`default_nettype wire

// File: rtl/cache_ctrl_perf_cnt.sv
// ============================================================================
//  Module   : cache_ctrl_cnt
//  Brief    : Single event counter with clear, freeze and wrap/saturate mode.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_ctrl_cnt #(
    parameter int CNT_W = 32,
    parameter int SAT   = 0
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             inc,
    input  wire logic             clr,
    input  wire logic             frz,
    output logic [CNT_W-1:0]      cnt
);
    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;

    // Clear wins over everything; freeze drops the event entirely.
    always_comb begin
        w_cnt_d = r_cnt_q;
        if (clr) begin
            w_cnt_d = '0;
        end else if (inc && !frz) begin
            if ((SAT != 0) && (&r_cnt_q)) begin
                w_cnt_d = r_cnt_q;
            end else begin
                w_cnt_d = r_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign cnt = r_cnt_q;

endmodule

`default_nettype wire

// File: rtl/cache_ctrl_perf.sv
// ============================================================================
//  Module   : cache_ctrl_perf
//  Brief    : Multi-channel hit/miss counters, buffer status and invalidate FSM.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_ctrl_perf
    import cache_ctrl_perf_pkg::*;
#(
    parameter int FE_DATA_W   = 32,
    parameter int CNT_W       = 32,
    parameter int N_CH        = 2,
    parameter int SAT         = 0,
    parameter int CTRL_ADDR_W = 5
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    cache_ctrl_perf_if.slave  bus
);
    localparam int N_CNT = int'(c_cnt_per_ch) * N_CH;
    localparam int SUM_W = CNT_W + $clog2(2 * N_CH);

    localparam logic [CTRL_ADDR_W-1:0] c_a_hit   = CTRL_ADDR_W'(c_addr_hit_total);
    localparam logic [CTRL_ADDR_W-1:0] c_a_miss  = CTRL_ADDR_W'(c_addr_miss_total);
    localparam logic [CTRL_ADDR_W-1:0] c_a_clr   = CTRL_ADDR_W'(c_addr_reset_cnt);
    localparam logic [CTRL_ADDR_W-1:0] c_a_inv   = CTRL_ADDR_W'(c_addr_invalidate);
    localparam logic [CTRL_ADDR_W-1:0] c_a_empty = CTRL_ADDR_W'(c_addr_buf_empty);
    localparam logic [CTRL_ADDR_W-1:0] c_a_full  = CTRL_ADDR_W'(c_addr_buf_full);
    localparam logic [CTRL_ADDR_W-1:0] c_a_fon   = CTRL_ADDR_W'(c_addr_freeze_on);
    localparam logic [CTRL_ADDR_W-1:0] c_a_foff  = CTRL_ADDR_W'(c_addr_freeze_off);

    state_e                 r_state_q, w_state_d;
    logic                   r_ready_q, w_ready_d;
    logic [FE_DATA_W-1:0]   r_rdata_q, w_rdata_d;
    logic                   r_invalidate_q, w_invalidate_d;
    logic                   r_freeze_q, w_freeze_d;
    logic                   w_clr;
    logic [N_CNT-1:0]       w_inc;
    logic [CNT_W-1:0]       w_cnt [N_CNT];
    logic [SUM_W-1:0]       w_hit_sum, w_miss_sum;
    logic [FE_DATA_W-1:0]   w_rd_val;

    // Counter k of channel ch lives at index ch*4+k: rd_hit, rd_miss, wr_hit, wr_miss.
    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        assign w_inc[ch*int'(c_cnt_per_ch) + 0] = bus.read_hit[ch];
        assign w_inc[ch*int'(c_cnt_per_ch) + 1] = bus.read_miss[ch];
        assign w_inc[ch*int'(c_cnt_per_ch) + 2] = bus.write_hit[ch];
        assign w_inc[ch*int'(c_cnt_per_ch) + 3] = bus.write_miss[ch];
    end

    for (genvar i = 0; i < N_CNT; i++) begin : g_cnt
        cache_ctrl_cnt #(
            .CNT_W (CNT_W),
            .SAT   (SAT)
        ) u_cnt (
            .clk     (clk),
            .reset_n (reset_n),
            .inc     (w_inc[i]),
            .clr     (w_clr),
            .frz     (r_freeze_q),
            .cnt     (w_cnt[i])
        );
    end

    function automatic logic [CNT_W-1:0] f_fold(input logic [SUM_W-1:0] s);
        if ((SAT != 0) && (s > SUM_W'({CNT_W{1'b1}}))) begin
            return '1;
        end
        return s[CNT_W-1:0];
    endfunction

    always_comb begin
        w_hit_sum  = '0;
        w_miss_sum = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            w_hit_sum  = w_hit_sum  + SUM_W'(w_cnt[ch*int'(c_cnt_per_ch) + 0])
                                    + SUM_W'(w_cnt[ch*int'(c_cnt_per_ch) + 2]);
            w_miss_sum = w_miss_sum + SUM_W'(w_cnt[ch*int'(c_cnt_per_ch) + 1])
                                    + SUM_W'(w_cnt[ch*int'(c_cnt_per_ch) + 3]);
        end
    end

    // Control addresses and unmapped addresses fall through to zero.
    always_comb begin
        w_rd_val = '0;
        case (bus.addr)
            c_a_hit:   w_rd_val = FE_DATA_W'(f_fold(w_hit_sum));
            c_a_miss:  w_rd_val = FE_DATA_W'(f_fold(w_miss_sum));
            c_a_empty: w_rd_val = FE_DATA_W'(bus.wtbuf_empty);
            c_a_full:  w_rd_val = FE_DATA_W'(bus.wtbuf_full);
            default: begin
                for (int i = 0; i < N_CNT; i++) begin
                    if (bus.addr == CTRL_ADDR_W'(int'(c_addr_cnt_base) + i)) begin
                        w_rd_val = FE_DATA_W'(w_cnt[i]);
                    end
                end
            end
        endcase
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_ready_d  = 1'b0;
        w_rdata_d  = '0;
        w_clr      = 1'b0;
        w_freeze_d = r_freeze_q;
        case (r_state_q)
            S_IDLE: begin
                if (bus.valid) begin
                    if (bus.addr == c_a_inv) begin
                        w_state_d = S_INV_WAIT;
                    end else begin
                        w_ready_d = 1'b1;
                        w_rdata_d = w_rd_val;
                        if (bus.addr == c_a_clr)  w_clr      = 1'b1;
                        if (bus.addr == c_a_fon)  w_freeze_d = 1'b1;
                        if (bus.addr == c_a_foff) w_freeze_d = 1'b0;
                    end
                end
            end
            S_INV_WAIT: begin
                if (bus.inv_done) begin
                    w_state_d = S_INV_ACK;
                    w_ready_d = 1'b1;
                end
            end
            S_INV_ACK: w_state_d = S_IDLE;
            default:   w_state_d = S_IDLE;
        endcase
        w_invalidate_d = (w_state_d == S_INV_WAIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state_q      <= S_IDLE;
            r_ready_q      <= 1'b0;
            r_rdata_q      <= '0;
            r_invalidate_q <= 1'b0;
            r_freeze_q     <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_ready_q      <= w_ready_d;
            r_rdata_q      <= w_rdata_d;
            r_invalidate_q <= w_invalidate_d;
            r_freeze_q     <= w_freeze_d;
        end
    end

    assign bus.rdata      = r_rdata_q;
    assign bus.ready      = r_ready_q;
    assign bus.invalidate = r_invalidate_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_ctrl_perf.sv
// ============================================================================
//  Module   : tb_cache_ctrl_perf
//  Brief    : Checks a wrapping and a saturating 4-bit instance side by side.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_ctrl_perf;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       valid = 1'b0;
    logic [4:0] addr = '0;
    logic       inv_done = 1'b0;
    logic       wtbuf_full = 1'b0;
    logic       wtbuf_empty = 1'b0;
    logic [1:0] rh = '0, rm = '0, wh = '0, wm = '0;

    always #5 clk = ~clk;

    cache_ctrl_perf_if #(.FE_DATA_W(32), .CTRL_ADDR_W(5), .N_CH(2)) bus0 ();
    cache_ctrl_perf_if #(.FE_DATA_W(32), .CTRL_ADDR_W(5), .N_CH(2)) bus1 ();

    assign bus0.valid = valid;        assign bus1.valid = valid;
    assign bus0.addr = addr;          assign bus1.addr = addr;
    assign bus0.inv_done = inv_done;  assign bus1.inv_done = inv_done;
    assign bus0.wtbuf_full = wtbuf_full;   assign bus1.wtbuf_full = wtbuf_full;
    assign bus0.wtbuf_empty = wtbuf_empty; assign bus1.wtbuf_empty = wtbuf_empty;
    assign bus0.read_hit = rh;        assign bus1.read_hit = rh;
    assign bus0.read_miss = rm;       assign bus1.read_miss = rm;
    assign bus0.write_hit = wh;       assign bus1.write_hit = wh;
    assign bus0.write_miss = wm;      assign bus1.write_miss = wm;

    cache_ctrl_perf #(.FE_DATA_W(32), .CNT_W(4), .N_CH(2), .SAT(0), .CTRL_ADDR_W(5))
        dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
    cache_ctrl_perf #(.FE_DATA_W(32), .CNT_W(4), .N_CH(2), .SAT(1), .CTRL_ADDR_W(5))
        dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

    typedef struct {
        int unsigned cyc;
        logic [31:0] e0;
        logic [31:0] e1;
        int          a;
    } exp_t;

    typedef struct {
        logic [1:0] rh, rm, wh, wm;
        int         n;
    } ev_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] e0;
        logic [31:0] e1;
    } rv_t;

    exp_t        sb[$];
    exp_t        m_e;
    int          n_chk = 0;
    int          n_fail = 0;
    int unsigned cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: each response must arrive exactly one cycle after its issue.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus0.ready || bus1.ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_ready", 32'(bus0.ready | bus1.ready), 0);
                end else begin
                    m_e = sb.pop_front();
                    check($sformatf("ready_pair[a%0d]", m_e.a), 32'(bus0.ready & bus1.ready), 1);
                    check($sformatf("latency[a%0d]", m_e.a), cyc_cnt - m_e.cyc, 1);
                    check($sformatf("rdata_wrap[a%0d]", m_e.a), bus0.rdata, m_e.e0);
                    check($sformatf("rdata_sat[a%0d]", m_e.a), bus1.rdata, m_e.e1);
                end
            end else if (sb.size() > 0 && cyc_cnt > sb[0].cyc + 1) begin
                m_e = sb.pop_front();
                check($sformatf("missing_ready[a%0d]", m_e.a), 0, 1);
            end
        end
    end

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic [1:0] h_r, m_r, h_w, m_w, input int n);
        for (int i = 0; i < n; i++) begin
            rh = h_r; rm = m_r; wh = h_w; wm = m_w;
            cyc1();
        end
        rh = '0; rm = '0; wh = '0; wm = '0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e0, input logic [31:0] e1);
        valid = 1'b1;
        addr  = a;
        sb.push_back('{cyc_cnt, e0, e1, int'(a)});
        cyc1();
        valid = 1'b0;
    endtask

    task automatic check_inv(input string nm, input logic exp);
        check({nm, "_wrap"}, 32'(bus0.invalidate), 32'(exp));
        check({nm, "_sat"},  32'(bus1.invalidate), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ev_t evs[3];
        rv_t rds[12];
        evs[0] = '{2'b01, 2'b00, 2'b00, 2'b00, 5};
        evs[1] = '{2'b00, 2'b00, 2'b00, 2'b10, 3};
        evs[2] = '{2'b01, 2'b01, 2'b01, 2'b01, 1};
        rds[0]  = '{5'd8,  6, 6};  rds[1]  = '{5'd9,  1, 1};
        rds[2]  = '{5'd10, 1, 1};  rds[3]  = '{5'd11, 1, 1};
        rds[4]  = '{5'd12, 0, 0};  rds[5]  = '{5'd13, 0, 0};
        rds[6]  = '{5'd14, 0, 0};  rds[7]  = '{5'd15, 3, 3};
        rds[8]  = '{5'd0,  7, 7};  rds[9]  = '{5'd1,  5, 5};
        rds[10] = '{5'd4,  1, 1};  rds[11] = '{5'd5,  0, 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus0.ready | bus1.ready), 0);
        check_inv("rst_inv", 1'b0);
        check("rst_rdata", bus0.rdata | bus1.rdata, 0);
        reset_n = 1'b1;
        cyc1();

        // Every register reads zero after reset, back to back
        for (int a = 0; a < 16; a++) if (a != 3) rd(5'(a), 0, 0);
        cyc1(); cyc1();

        // Table-driven counting and totals
        for (int i = 0; i < 3; i++) ev(evs[i].rh, evs[i].rm, evs[i].wh, evs[i].wm, evs[i].n);
        wtbuf_empty = 1'b1;
        for (int i = 0; i < 12; i++) rd(rds[i].a, rds[i].e0, rds[i].e1);
        wtbuf_empty = 1'b0; wtbuf_full = 1'b1;
        rd(5'd5, 1, 1);
        rd(5'd4, 0, 0);
        wtbuf_full = 1'b0;

        // Wrap versus saturate, and the clamped/truncated totals
        rd(5'd2, 0, 0);
        ev(2'b01, 2'b00, 2'b00, 2'b00, 17);
        rd(5'd8, 1, 15);
        rd(5'd2, 0, 0);
        ev(2'b11, 2'b00, 2'b11, 2'b00, 15);
        rd(5'd0, 12, 15);
        rd(5'd8, 15, 15);
        rd(5'd14, 15, 15);
        ev(2'b11, 2'b00, 2'b11, 2'b00, 1);
        rd(5'd0, 0, 15);
        rd(5'd8, 0, 15);
        rd(5'd1, 0, 0);

        // Freeze drops events; clear beats a same-cycle event
        rd(5'd2, 0, 0);
        rd(5'd6, 0, 0);
        ev(2'b01, 2'b00, 2'b00, 2'b00, 10);
        rd(5'd8, 0, 0);
        rd(5'd7, 0, 0);
        ev(2'b01, 2'b00, 2'b00, 2'b00, 2);
        rd(5'd8, 2, 2);
        rh = 2'b01;
        rd(5'd2, 0, 0);
        rh = 2'b00;
        rd(5'd8, 0, 0);

        // Invalidate: requests ignored while waiting, counting continues
        valid = 1'b1; addr = 5'd3;
        cyc1();
        for (int i = 0; i < 20; i++) begin
            check_inv($sformatf("inv_wait%0d", i), 1'b1);
            rh    = 2'b10;
            valid = 1'b1;
            addr  = 5'(i % 8);
            cyc1();
        end
        valid = 1'b0; rh = 2'b00;
        check_inv("inv_hold", 1'b1);
        inv_done = 1'b1;
        sb.push_back('{cyc_cnt, 0, 0, 3});
        cyc1();
        inv_done = 1'b0;
        check_inv("inv_ack", 1'b0);
        cyc1();
        check_inv("inv_idle", 1'b0);
        rd(5'd12, 4, 15);
        rd(5'd8, 0, 0);

        // Stray inv_done in IDLE does nothing
        inv_done = 1'b1;
        cyc1();
        inv_done = 1'b0;
        cyc1();
        check_inv("stray_done", 1'b0);

        // Reset in the middle of an invalidate
        valid = 1'b1; addr = 5'd3;
        cyc1();
        valid = 1'b0;
        cyc1();
        check_inv("pre_rst_inv", 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check_inv("async_rst_inv", 1'b0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        rd(5'd12, 0, 0);
        rd(5'd0, 0, 0);
        cyc1(); cyc1(); cyc1();
        check("sb_left", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
